// File: rtl/key_event_engine.sv
// key_event_engine: debounced multi-key front end producing press, release, long-press and auto-repeat events
module key_event_engine #(
    parameter int NUM_KEYS     = 4,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int HOLD_CYC     = 50_000_000,
    parameter int REPEAT_CYC   = 5_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] level,
    output logic [NUM_KEYS-1:0] press,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long,
    output logic [NUM_KEYS-1:0] rpt,
    output logic                any_press
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int RW = $clog2(REPEAT_CYC + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYC - 1);
    localparam logic [NUM_KEYS-1:0] IDLE_PIN = {NUM_KEYS{ACTIVE_LOW}};

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    logic [NUM_KEYS-1:0] sync1, sync2, pressed, press_nxt;

    // two-flop synchroniser, parked at the released pin value while in reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= IDLE_PIN;
            sync2 <= IDLE_PIN;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    assign pressed = ACTIVE_LOW ? ~sync2 : sync2;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [DW-1:0] db_cnt;
        logic [HW-1:0] hold_cnt, hold_nxt;
        logic [RW-1:0] rep_cnt, rep_nxt;
        state_t        state, state_nxt;
        logic          lvl, prs, rel, lng, rp;
        logic          prs_nxt, rel_nxt, lng_nxt, rp_nxt;

        // debounce: level flips only after DEBOUNCE_CYC consecutive cycles of disagreement
        always_ff @(posedge clk) begin
            if (!reset) begin
                db_cnt <= '0;
                lvl    <= 1'b0;
            end else if (pressed[i] == lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                lvl    <= ~lvl;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end

        // next state, counters and event pulses from the debounced level
        always_comb begin
            state_nxt = state;
            hold_nxt  = hold_cnt;
            rep_nxt   = rep_cnt;
            prs_nxt   = 1'b0;
            rel_nxt   = 1'b0;
            lng_nxt   = 1'b0;
            rp_nxt    = 1'b0;
            case (state)
                IDLE: if (lvl) begin
                    prs_nxt   = 1'b1;
                    rp_nxt    = 1'b1;
                    hold_nxt  = '0;
                    state_nxt = WAIT;
                end
                WAIT: if (!lvl) begin
                    rel_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    lng_nxt   = 1'b1;
                    rp_nxt    = repeat_en[i];
                    rep_nxt   = '0;
                    state_nxt = HOLD;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
                HOLD: if (!lvl) begin
                    rel_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (rep_cnt == REP_LAST) begin
                    rp_nxt  = repeat_en[i];
                    rep_nxt = '0;
                end else begin
                    rep_nxt = rep_cnt + 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end

        // state, counters and registered event outputs
        always_ff @(posedge clk) begin
            if (!reset) begin
                state    <= IDLE;
                hold_cnt <= '0;
                rep_cnt  <= '0;
                prs      <= 1'b0;
                rel      <= 1'b0;
                lng      <= 1'b0;
                rp       <= 1'b0;
            end else begin
                state    <= state_nxt;
                hold_cnt <= hold_nxt;
                rep_cnt  <= rep_nxt;
                prs      <= prs_nxt;
                rel      <= rel_nxt;
                lng      <= lng_nxt;
                rp       <= rp_nxt;
            end
        end

        assign level[i]         = lvl;
        assign press[i]         = prs;
        assign release_pulse[i] = rel;
        assign long[i]          = lng;
        assign rpt[i]           = rp;
        assign press_nxt[i]     = prs_nxt;
    end

    // any_press registered alongside the per-key press flops so it lines up with them
    always_ff @(posedge clk) any_press <= reset ? |press_nxt : 1'b0;
endmodule

// File: doc/key_event_engine.md
Name: key_event_engine

Overview:
Multi-channel front end for push-button keys on the watch board. It converts raw asynchronous key pins into clean, clock-synchronous events for the mode FSMs (clock, stopwatch, countdown, game):
- debounced level
- one-cycle press and release pulses
- a one-cycle long-press pulse
- an auto-repeat pulse train while a key is held

It generalises the single-key edge and press-hold logic to NUM_KEYS independent channels, with debounce, selectable polarity and per-key repeat masking.

Parameters:
NUM_KEYS, 4, number of independent key channels
ACTIVE_LOW, 1, 1: raw pin low = pressed; 0: raw pin high = pressed
DEBOUNCE_CYC, 500_000, consecutive stable cycles required to accept a level change (>=1); 10 ms at 50 MHz
HOLD_CYC, 50_000_000, cycles from press pulse to long pulse (>=1); 1 s
REPEAT_CYC, 5_000_000, auto-repeat period after long pulse (>=1); 10 Hz

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
key_raw  input  NUM_KEYS  raw asynchronous key pins
repeat_en  input  NUM_KEYS  per-key enable for auto-repeat pulses after the long pulse
level  output  NUM_KEYS  debounced pressed level (1 = pressed)
press  output  NUM_KEYS  one-cycle pulse on debounced press
release  output  NUM_KEYS  one-cycle pulse on debounced release
long  output  NUM_KEYS  one-cycle pulse when held HOLD_CYC cycles
rpt  output  NUM_KEYS  press pulse plus auto-repeat train
any_press  output  1  OR of press

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs, counters, FSM states and synchroniser flops clear.
  - Synchronisers clear to the released value.
  - level=0; no pulses are generated during reset.
- Per-channel pipeline:
  - 2-flop synchroniser.
  - Polarity normalise: pressed = ACTIVE_LOW ? ~sync : sync.
  - Debounce counter (width $clog2(DEBOUNCE_CYC+1)):
    - Counter clears whenever pressed == level.
    - Otherwise it increments.
    - When it reaches DEBOUNCE_CYC, level toggles and the counter clears.
    - Any bounce back before DEBOUNCE_CYC restarts the count; level never changes.
- Latency: for a clean transition first sampled at edge t, press (or release) is high in the cycle after edge t+DEBOUNCE_CYC+2 (2 sync + DEBOUNCE_CYC filter + 1 output register). Total: DEBOUNCE_CYC+3 edges.
- Per-channel FSM, advancing on debounced level:
  - IDLE:
    - level rises → press=1, rpt=1 (same cycle); hold counter clears; go to WAIT.
  - WAIT:
    - Hold counter increments each cycle.
    - level falls → release=1; go to IDLE; no long.
    - Count reaches HOLD_CYC (long is exactly HOLD_CYC cycles after press) → long=1; rpt=1 if repeat_en[i]; repeat counter clears; go to HOLD.
  - HOLD:
    - Repeat counter increments.
    - Every REPEAT_CYC cycles, rpt=1 if repeat_en[i]; counter wraps to 0.
    - level falls → release=1; go to IDLE; rpt stops immediately.
- repeat_en:
  - Sampled each cycle.
  - Affects only rpt pulses issued in the WAIT→HOLD transition and in HOLD.
  - press, long and release are never masked.
- All outputs are registered. Pulses are exactly one cycle wide; a held key never re-issues press.
- Channels are fully independent. Simultaneous events on different keys are all reported in the same cycle.
- Reset mid-operation: outputs go 0 on the next edge.
  - Key still held when reset deasserts: normal debounce runs; a fresh press appears DEBOUNCE_CYC+3 cycles later.
  - No release is generated for the reset-truncated press.
- Counter widths:
  - Hold counter: $clog2(HOLD_CYC+1).
  - Repeat counter: $clog2(REPEAT_CYC+1).
  - No overflow is possible, since counters clear on state exit.

Test Plan:
Bench parameters: NUM_KEYS=2, ACTIVE_LOW=1, DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=5.
1. Reset low 3 cycles, keys high; release reset; drive key_raw[0]=0 from edge t → all outputs 0 through t+6; press[0]=rpt[0]=any_press=1 for one cycle after edge t+6; level[0]=1 thereafter.
2. Toggle key_raw[0] every 2 cycles for 30 cycles, then return high → level, press, release, long, rpt all stay 0.
3. Hold key0 low 60 cycles, repeat_en=11 → long[0] at press+20; rpt[0] at press, press+20, +25, +30, ...; raise key → release[0] 7 cycles after the raw rise; no rpt after release.
4. Key0 low 12 cycles then high → press[0], then release[0] 12 cycles later; long[0] never asserts.
5. Both keys pressed on the same edge, repeat_en=01, held 40 cycles → press[1:0]=11 in the same cycle; long[1:0]=11 at press+20; key1 rpt only at press and never after long; key0 repeats every 5 cycles.
6. Key0 held into HOLD; assert reset 2 cycles mid-hold with key still low → all outputs 0 during reset; no release; fresh press[0] 7 cycles after reset deasserts; long 20 cycles after that.
